// File: rtl/axi_pkg.sv
// Shared AXI encodings and state types for the write-side (and future read-side) SRAM responders.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wslv_state_t;

    // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address calculator (FIXED / INCR / WRAP), shared by both responders.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;

    assign step         = ADDR_WIDTH'(1) << size;
    assign aligned_addr = addr & ~(step - ADDR_WIDTH'(1));
    assign incr_addr    = aligned_addr + step;
    // Window is (len+1) transfers; only the bits inside it advance, so the address rolls to the base.
    assign wrap_mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_w_sram.sv
// AXI4 write-channel responder: one AW, its W burst written beat-by-beat into a single-port SRAM, then B.
module axi_slave_w_sram
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 1,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_AW     = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [STRB_WIDTH-1:0] mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

    localparam int LANE_BITS = $clog2(STRB_WIDTH);

    wslv_state_t           state_reg, state_next;
    logic [ID_WIDTH-1:0]   id_reg, id_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]            len_reg, len_next;
    logic [2:0]            size_reg, size_next;
    logic [1:0]            burst_reg, burst_next;
    logic [7:0]            cnt_reg, cnt_next;
    logic                  err_reg, err_next;
    logic                  awready_reg, awready_next;
    logic                  wready_reg, wready_next;
    logic                  bvalid_reg, bvalid_next;
    logic [ID_WIDTH-1:0]   bid_reg, bid_next;
    logic [1:0]            bresp_reg, bresp_next;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  final_beat;
    logic                  wlast_bad;
    logic                  req_err;
    logic                  beat_write;
    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] next_addr;

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .addr      (addr_reg),
        .len       (len_reg),
        .size      (size_reg),
        .burst     (burst_reg),
        .next_addr (next_addr)
    );

    assign aw_hs      = AWVALID && awready_reg;
    assign w_hs       = WVALID && wready_reg;
    assign b_hs       = BREADY && bvalid_reg;
    assign final_beat = (cnt_reg == len_reg);
    assign wlast_bad  = WLAST ^ final_beat;

    // A bad request is still fully consumed; it just never reaches the SRAM.
    assign size_mask = (ADDR_WIDTH'(1) << AWSIZE) - ADDR_WIDTH'(1);
    assign req_err   = (AWSIZE > 3'(LANE_BITS))
                     || (AWBURST == BURST_RSVD)
                     || ((AWBURST == BURST_WRAP)
                         && (!wrap_len_ok(AWLEN) || ((AWADDR & size_mask) != '0)));

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        size_next  = size_reg;
        burst_next = burst_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        bid_next   = bid_reg;
        bresp_next = bresp_reg;

        case (state_reg)
            IDLE: begin
                if (aw_hs) begin
                    id_next    = AWID;
                    addr_next  = AWADDR;
                    len_next   = AWLEN;
                    size_next  = AWSIZE;
                    burst_next = AWBURST;
                    cnt_next   = 8'd0;
                    err_next   = req_err;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    cnt_next  = cnt_reg + 8'd1;
                    addr_next = next_addr;
                    err_next  = err_reg | wlast_bad;
                    if (final_beat) begin
                        bid_next   = id_reg;
                        bresp_next = (err_reg || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    bid_next   = '0;
                    bresp_next = RESP_OKAY;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Handshake outputs are registered decodes of the upcoming state.
        awready_next = (state_next == IDLE);
        wready_next  = (state_next == DATA);
        bvalid_next  = (state_next == RESP);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg   <= IDLE;
            id_reg      <= '0;
            addr_reg    <= '0;
            len_reg     <= '0;
            size_reg    <= '0;
            burst_reg   <= '0;
            cnt_reg     <= '0;
            err_reg     <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bid_reg     <= '0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            state_reg   <= state_next;
            id_reg      <= id_next;
            addr_reg    <= addr_next;
            len_reg     <= len_next;
            size_reg    <= size_next;
            burst_reg   <= burst_next;
            cnt_reg     <= cnt_next;
            err_reg     <= err_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            bvalid_reg  <= bvalid_next;
            bid_reg     <= bid_next;
            bresp_reg   <= bresp_next;
        end
    end

    assign AWREADY = awready_reg;
    assign WREADY  = wready_reg;
    assign BVALID  = bvalid_reg;
    assign BID     = bid_reg;
    assign BRESP   = bresp_reg;

    assign beat_write = w_hs && !err_reg;
    assign mem_addr   = MEM_AW'(addr_reg >> LANE_BITS);
    assign mem_wdata  = WDATA;

    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane_we
        assign mem_we[gi] = beat_write && WSTRB[gi];
    end

endmodule

// File: tb/tb_axi_slave_w_sram.sv
// Self-checking bench for axi_slave_w_sram: burst-level reference model plus directed bursts with literal expectations.
module tb_axi_slave_w_sram;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [0:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [0:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [3:0]  mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;

    axi_slave_w_sram dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // ---------------- reference model (burst-level) ----------------
    int          m_phase = 0;     // 0 waiting for request, 1 taking data, 2 responding
    logic        m_awready = 0, m_wready = 0, m_bvalid = 0;
    logic [0:0]  m_id = 0, m_bid = 0;
    logic [1:0]  m_bresp = 0, m_burst = 0;
    logic [31:0] m_addr = 0;
    logic [2:0]  m_size = 0;
    int          m_len = 0, m_beat = 0;
    logic        m_err = 0;

    function automatic logic [31:0] model_next(logic [31:0] a, int len, logic [2:0] size, logic [1:0] burst);
        longint bytes = longint'(1) << size;
        longint win   = longint'(len + 1) * bytes;
        longint base;
        if (burst == 2'b01) return 32'(((longint'(a) / bytes) * bytes) + bytes);
        if (burst == 2'b10) begin
            base = (longint'(a) / win) * win;
            return 32'(base + ((longint'(a) - base + bytes) % win));
        end
        return a;
    endfunction

    function automatic logic model_req_err(logic [31:0] a, int len, logic [2:0] size, logic [1:0] burst);
        if (size > 3'd2) return 1'b1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (burst == 2'b10 && (longint'(a) % (longint'(1) << size)) != 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge ACLK or posedge ARESET);
            if (ARESET) begin
                m_phase = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
                m_bid = 0; m_bresp = 0; m_err = 0;
            end else begin
                if (m_phase == 0 && AWVALID && m_awready) begin
                    m_id = AWID; m_addr = AWADDR; m_len = int'(AWLEN); m_size = AWSIZE; m_burst = AWBURST;
                    m_beat = 0; m_err = model_req_err(AWADDR, int'(AWLEN), AWSIZE, AWBURST);
                    m_phase = 1;
                end else if (m_phase == 1 && WVALID && m_wready) begin
                    if (WLAST != (m_beat == m_len)) m_err = 1'b1;
                    m_addr = model_next(m_addr, m_len, m_size, m_burst);
                    if (m_beat == m_len) begin
                        m_bresp = m_err ? 2'b10 : 2'b00;
                        m_bid = m_id;
                        m_phase = 2;
                    end
                    m_beat++;
                end else if (m_phase == 2 && BREADY && m_bvalid) begin
                    m_phase = 0;
                end
                m_awready = (m_phase == 0);
                m_wready  = (m_phase == 1);
                m_bvalid  = (m_phase == 2);
            end
        end
    end

    // ---------------- per-cycle comparison and beat capture ----------------
    logic [15:0] cap_addr[$];
    logic [3:0]  cap_we[$];

    initial begin
        logic acc;
        forever begin
            @(negedge ACLK);
            acc = (m_phase == 1) && m_wready && WVALID;
            chk("awready", AWREADY, m_awready);
            chk("wready", WREADY, m_wready);
            chk("bvalid", BVALID, m_bvalid);
            if (m_bvalid) begin
                chk("bid", BID, m_bid);
                chk("bresp", BRESP, m_bresp);
            end
            chk("mem_we", mem_we, (acc && !m_err) ? WSTRB : 4'h0);
            if (acc && !m_err) begin
                chk("mem_addr", mem_addr, 16'(m_addr >> 2));
                chk("mem_wdata", mem_wdata, WDATA);
            end
            if (WVALID && WREADY) begin
                cap_addr.push_back(mem_addr);
                cap_we.push_back(mem_we);
            end
        end
    end

    // ---------------- stimulus helpers (all start and end #1 after a rising edge) ----------------
    task automatic aw_send(input logic [0:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic got = 1'b0;
        cap_addr.delete(); cap_we.delete();
        AWID = id; AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (AWREADY) got = 1'b1;
            @(posedge ACLK); #1;
            if (got) break;
        end
        AWVALID = 1'b0;
        if (!got) chk("aw_timeout", 0, 1);
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l, input int gap);
        logic got = 1'b0;
        repeat (gap) begin @(posedge ACLK); #1; end
        WVALID = 1'b1; WDATA = d; WSTRB = s; WLAST = l;
        for (int k = 0; k < 50; k++) begin
            @(negedge ACLK);
            if (WREADY) got = 1'b1;
            @(posedge ACLK); #1;
            if (got) break;
        end
        WVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
        if (!got) chk("w_timeout", 0, 1);
    endtask

    task automatic b_take(input string n, input int hold, input logic [1:0] resp, input logic [0:0] id);
        @(negedge ACLK);
        chk({n, "_bvalid_l1"}, BVALID, 1);
        repeat (hold) begin
            @(posedge ACLK); #1; AWVALID = 1'b1;
            @(negedge ACLK);
            chk({n, "_hold_awready"}, AWREADY, 0);
            chk({n, "_hold_bresp"}, BRESP, resp);
        end
        @(posedge ACLK); #1; AWVALID = 1'b0; BREADY = 1'b1;
        @(negedge ACLK);
        chk({n, "_bresp"}, BRESP, resp);
        chk({n, "_bid"}, BID, id);
        @(posedge ACLK); #1; BREADY = 1'b0;
        @(negedge ACLK);
        chk({n, "_rearm"}, AWREADY, 1);
        @(posedge ACLK); #1;
    endtask

    task automatic beat_chk(input string n, input int i, input logic [15:0] a, input logic [3:0] we);
        if (i >= cap_addr.size()) chk($sformatf("%s_beats", n), cap_addr.size(), i + 1);
        else begin
            if (we != 4'h0) chk($sformatf("%s_addr%0d", n, i), cap_addr[i], a);
            chk($sformatf("%s_we%0d", n, i), cap_we[i], we);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_mem_we", mem_we, 0);
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("first_awready", AWREADY, 1);

        // single-beat INCR
        aw_send(1'b1, 32'h40, 8'd0, 3'd2, 2'b01);
        w_send(32'hDEADBEEF, 4'hF, 1'b1, 0);
        beat_chk("t1", 0, 16'h10, 4'hF);
        b_take("t1", 0, 2'b00, 1'b1);

        // W presented while idle must not be taken
        WVALID = 1'b1; WDATA = 32'h1234; WSTRB = 4'hF;
        repeat (2) begin @(posedge ACLK); #1; end
        WVALID = 1'b0; WDATA = '0; WSTRB = '0;

        // 4-beat INCR with a WVALID gap
        aw_send(1'b0, 32'h100, 8'd3, 3'd2, 2'b01);
        w_send(32'h11111111, 4'hF, 1'b0, 0);
        w_send(32'h22222222, 4'h3, 1'b0, 2);
        w_send(32'h33333333, 4'hC, 1'b0, 0);
        w_send(32'h44444444, 4'h0, 1'b1, 0);
        beat_chk("t2", 0, 16'h40, 4'hF); beat_chk("t2", 1, 16'h41, 4'h3);
        beat_chk("t2", 2, 16'h42, 4'hC); beat_chk("t2", 3, 16'h43, 4'h0);
        b_take("t2", 0, 2'b00, 1'b0);

        // WRAP4 at 0x1C
        aw_send(1'b1, 32'h1C, 8'd3, 3'd2, 2'b10);
        for (int i = 0; i < 4; i++) w_send(32'hA0 + i, 4'hF, i == 3, 0);
        beat_chk("t3", 0, 16'h7, 4'hF); beat_chk("t3", 1, 16'h4, 4'hF);
        beat_chk("t3", 2, 16'h5, 4'hF); beat_chk("t3", 3, 16'h6, 4'hF);
        b_take("t3", 0, 2'b00, 1'b1);

        // FIXED 3-beat at 0x20
        aw_send(1'b0, 32'h20, 8'd2, 3'd2, 2'b00);
        for (int i = 0; i < 3; i++) w_send(32'hB0 + i, 4'h5, i == 2, 0);
        for (int i = 0; i < 3; i++) beat_chk("t4", i, 16'h8, 4'h5);
        b_take("t4", 0, 2'b00, 1'b0);

        // WRAP with illegal length
        aw_send(1'b1, 32'h0, 8'd2, 3'd2, 2'b10);
        for (int i = 0; i < 3; i++) w_send(32'hC0 + i, 4'hF, i == 2, 0);
        for (int i = 0; i < 3; i++) beat_chk("t5", i, 16'h0, 4'h0);
        b_take("t5", 0, 2'b10, 1'b1);

        // oversize transfer
        aw_send(1'b0, 32'h0, 8'd1, 3'd3, 2'b01);
        for (int i = 0; i < 2; i++) w_send(32'hD0 + i, 4'hF, i == 1, 0);
        for (int i = 0; i < 2; i++) beat_chk("t6", i, 16'h0, 4'h0);
        b_take("t6", 0, 2'b10, 1'b0);

        // early WLAST on beat 2, then BREADY held low
        aw_send(1'b1, 32'h200, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) w_send(32'hE0 + i, 4'hF, i == 1, 0);
        beat_chk("t7", 0, 16'h80, 4'hF); beat_chk("t7", 1, 16'h81, 4'hF);
        beat_chk("t7", 2, 16'h0, 4'h0);  beat_chk("t7", 3, 16'h0, 4'h0);
        b_take("t7", 5, 2'b10, 1'b1);

        // missing WLAST on the final beat
        aw_send(1'b0, 32'h300, 8'd1, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) w_send(32'hF0 + i, 4'hF, 1'b0, 0);
        beat_chk("t8", 0, 16'hC0, 4'hF); beat_chk("t8", 1, 16'hC1, 4'hF);
        b_take("t8", 0, 2'b10, 1'b0);

        // reset after beat 2 of 8
        aw_send(1'b1, 32'h400, 8'd7, 3'd2, 2'b01);
        w_send(32'h5A5A0001, 4'hF, 1'b0, 0);
        w_send(32'h5A5A0002, 4'hF, 1'b0, 0);
        beat_chk("t9", 1, 16'h101, 4'hF);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("t9_rst_awready", AWREADY, 0);
        chk("t9_rst_wready", WREADY, 0);
        chk("t9_rst_bvalid", BVALID, 0);
        chk("t9_rst_bid", BID, 0);
        chk("t9_rst_bresp", BRESP, 0);
        chk("t9_rst_mem_we", mem_we, 0);
        chk("t9_rst_mem_addr", mem_addr, 0);
        chk("t9_rst_mem_wdata", mem_wdata, 0);
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("t9_awready_after", AWREADY, 1);
        aw_send(1'b1, 32'h44, 8'd0, 3'd2, 2'b01);
        w_send(32'hCAFEF00D, 4'h9, 1'b1, 0);
        beat_chk("t10", 0, 16'h11, 4'h9);
        b_take("t10", 0, 2'b00, 1'b1);

        repeat (2) @(posedge ACLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
